// File: rtl/mcdf_chnl_slave_p_pkg.sv
// Shared helpers for the parametrised MCDF channel slave: pointer/count sizing
// and the per-beat parity check.
package mcdf_pkg_p;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int PARITY_MAX_W   = 1024;

  function automatic int calc_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int PTR_W = calc_ptr_w(FIFO_DEPTH_DEF);
  localparam int CNT_W = PTR_W + 1;

  // Zero-extension does not change the XOR reduction, so one wide argument serves every DATA_W.
  function automatic logic parity_ok(input logic [PARITY_MAX_W-1:0] data,
                                     input logic p, input logic odd);
    return p == ((^data) ^ odd);
  endfunction

endpackage

// File: rtl/mcdf_chnl_slave_p_if.sv
// Channel-side and consumer-side signals of the MCDF channel slave.
interface mcdf_chnl_slave_p_if
  import mcdf_pkg_p::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ERR_CNT_W  = 8
);
  localparam int MARGIN_W = calc_ptr_w(FIFO_DEPTH) + 1;

  logic                 ch_en;
  logic [DATA_W-1:0]    ch_data;
  logic                 ch_data_p;
  logic                 ch_valid;
  logic                 ch_wait;
  logic                 ch_parity_err;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_clr;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic                 out_ready;
  logic [MARGIN_W-1:0]  fifo_margin;

  modport slave (
    input  ch_en, ch_data, ch_data_p, ch_valid, err_clr, out_ready,
    output ch_wait, ch_parity_err, err_sticky, err_cnt, out_valid, out_data, fifo_margin
  );

  modport master (
    output ch_en, ch_data, ch_data_p, ch_valid, err_clr, out_ready,
    input  ch_wait, ch_parity_err, err_sticky, err_cnt, out_valid, out_data, fifo_margin
  );

endinterface

// File: rtl/mcdf_chnl_slave_p_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible the cycle after the write.
module mcdf_sync_fifo
  import mcdf_pkg_p::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_pop,
  output logic [DATA_W-1:0]           o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [calc_ptr_w(DEPTH):0]  o_count
);
  localparam int PTR_W = calc_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mcdf_chnl_slave_p.sv
// MCDF channel slave: parity-checks each accepted beat, drops bad ones, buffers good ones.
module mcdf_chnl_slave_p
  import mcdf_pkg_p::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  mcdf_chnl_slave_p_if.slave bus
);
  localparam int L_PTR_W = calc_ptr_w(FIFO_DEPTH);
  localparam int L_CNT_W = L_PTR_W + 1;

  logic                 w_full;
  logic                 w_empty;
  logic [L_CNT_W-1:0]   w_count;
  logic                 w_beat;
  logic                 w_bad;
  logic                 w_push;
  logic                 r_parity_err;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // A beat completes whenever it is offered without backpressure, good or bad.
  assign bus.ch_wait = rst | ~bus.ch_en | w_full;
  assign w_beat      = bus.ch_valid & ~bus.ch_wait;
  assign w_bad       = ~parity_ok(PARITY_MAX_W'(bus.ch_data), bus.ch_data_p, ODD_PARITY);
  assign w_push      = w_beat & ~w_bad;

  mcdf_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.ch_data),
    .i_pop   (bus.out_ready),
    .o_data  (bus.out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.out_valid   = ~w_empty;
  assign bus.fifo_margin = L_CNT_W'(FIFO_DEPTH) - w_count;

  // Clear wins over a same-cycle error; the pulse itself is still reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_parity_err <= w_beat & w_bad;
      if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end else if (w_beat & w_bad) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.ch_parity_err = r_parity_err;
  assign bus.err_sticky    = r_err_sticky;
  assign bus.err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_mcdf_chnl_slave_p.sv
// Directed bench: dut0 even parity with 2-bit error counter, dut1 odd parity.
module tb_mcdf_chnl_slave_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcdf_chnl_slave_p_if #(.DATA_W(32), .FIFO_DEPTH(16), .ERR_CNT_W(2)) bus0 ();
  mcdf_chnl_slave_p_if #(.DATA_W(32), .FIFO_DEPTH(16), .ERR_CNT_W(8)) bus1 ();

  mcdf_chnl_slave_p #(.DATA_W(32), .FIFO_DEPTH(16), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mcdf_chnl_slave_p #(.DATA_W(32), .FIFO_DEPTH(16), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus0.ch_wait !== 1'b1) begin errors++; $display("FAIL reset_wait got %0b want 1", bus0.ch_wait); end
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.fifo_margin !== 5'd16) begin errors++; $display("FAIL reset_margin got %0d want 16", bus0.fifo_margin); end
    checks++; if ({bus0.ch_parity_err, bus0.err_sticky, bus0.err_cnt} !== 4'b0) begin
      errors++; $display("FAIL reset_err got perr=%0b sticky=%0b cnt=%0d want 0", bus0.ch_parity_err, bus0.err_sticky, bus0.err_cnt); end
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_stream();
    logic [31:0] d [4] = '{32'h1, 32'h3, 32'h7, 32'hF};
    logic        p [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus0.ch_en = 1'b1; bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.ch_valid = 1'b1; bus0.ch_data = d[i]; bus0.ch_data_p = p[i];
      #1;
      checks++; if (bus0.ch_wait !== 1'b0) begin errors++; $display("FAIL stream_wait[%0d] got %0b want 0", i, bus0.ch_wait); end
      tick();
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== d[i]) begin
        errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h want v=1 d=%h", i, bus0.out_valid, bus0.out_data, d[i]); end
      $display("stream: beat %0d data=%h", i, bus0.out_data);
    end
    bus0.ch_valid = 1'b0;
    tick();
    checks++; if (bus0.out_valid !== 1'b0 || bus0.fifo_margin !== 5'd16 || bus0.err_cnt !== 2'd0) begin
      errors++; $display("FAIL stream_end got v=%0b margin=%0d cnt=%0d want 0/16/0", bus0.out_valid, bus0.fifo_margin, bus0.err_cnt); end
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 32'h100 + 32'(i);
      bus0.ch_valid = 1'b1; bus0.ch_data = d; bus0.ch_data_p = ^d;
      #1;
      checks++; if (bus0.ch_wait !== 1'b0) begin errors++; $display("FAIL fill_wait[%0d] got %0b want 0", i, bus0.ch_wait); end
      tick();
    end
    d = 32'h110; bus0.ch_data = d; bus0.ch_data_p = ^d;
    #1;
    checks++; if (bus0.fifo_margin !== 5'd0) begin errors++; $display("FAIL fill_margin got %0d want 0", bus0.fifo_margin); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus0.ch_wait !== 1'b1) begin errors++; $display("FAIL full_wait[%0d] got %0b want 1", i, bus0.ch_wait); end
      tick();
    end
    checks++; if (bus0.fifo_margin !== 5'd0) begin errors++; $display("FAIL full_hold_margin got %0d want 0", bus0.fifo_margin); end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    #1;
    checks++; if (bus0.ch_wait !== 1'b0 || bus0.fifo_margin !== 5'd1) begin
      errors++; $display("FAIL pop_full got wait=%0b margin=%0d want 0/1", bus0.ch_wait, bus0.fifo_margin); end
    tick();
    checks++; if (bus0.ch_wait !== 1'b1 || bus0.fifo_margin !== 5'd0) begin
      errors++; $display("FAIL refill got wait=%0b margin=%0d want 1/0", bus0.ch_wait, bus0.fifo_margin); end
    bus0.ch_valid = 1'b0; bus0.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      d = 32'h100 + 32'(i);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== d) begin
        errors++; $display("FAIL drain[%0d] got v=%0b d=%h want v=1 d=%h", i, bus0.out_valid, bus0.out_data, d); end
      tick();
    end
    checks++; if (bus0.out_valid !== 1'b0 || bus0.fifo_margin !== 5'd16) begin
      errors++; $display("FAIL drain_end got v=%0b margin=%0d want 0/16", bus0.out_valid, bus0.fifo_margin); end
    bus0.out_ready = 1'b0;
    $display("fill: 16 stored, 17th after one pop, drained");
  endtask

  task automatic test_parity_err();
    bus0.ch_valid = 1'b1; bus0.ch_data = 32'h1; bus0.ch_data_p = 1'b0;
    tick();
    bus0.ch_valid = 1'b0;
    checks++; if (bus0.ch_parity_err !== 1'b1 || bus0.err_sticky !== 1'b1 || bus0.err_cnt !== 2'd1) begin
      errors++; $display("FAIL perr got perr=%0b sticky=%0b cnt=%0d want 1/1/1", bus0.ch_parity_err, bus0.err_sticky, bus0.err_cnt); end
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL perr_drop got v=%0b want 0", bus0.out_valid); end
    tick();
    checks++; if (bus0.ch_parity_err !== 1'b0 || bus0.err_sticky !== 1'b1) begin
      errors++; $display("FAIL perr_pulse got perr=%0b sticky=%0b want 0/1", bus0.ch_parity_err, bus0.err_sticky); end
    bus0.ch_valid = 1'b1; bus0.ch_data = 32'h1; bus0.ch_data_p = 1'b1;
    tick();
    bus0.ch_valid = 1'b0;
    checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 32'h1 || bus0.ch_parity_err !== 1'b0) begin
      errors++; $display("FAIL perr_next got v=%0b d=%h perr=%0b want 1/1/0", bus0.out_valid, bus0.out_data, bus0.ch_parity_err); end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    $display("parity_err: bad beat dropped, good beat stored");
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    bus0.err_clr = 1'b1;
    tick();
    bus0.err_clr = 1'b0;
    checks++; if (bus0.err_cnt !== 2'd0 || bus0.err_sticky !== 1'b0) begin
      errors++; $display("FAIL clr0 got cnt=%0d sticky=%0b want 0/0", bus0.err_cnt, bus0.err_sticky); end
    bus0.ch_valid = 1'b1; bus0.ch_data = 32'h3; bus0.ch_data_p = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      checks++; if (bus0.err_cnt !== exp_cnt) begin errors++; $display("FAIL sat[%0d] got %0d want %0d", i, bus0.err_cnt, exp_cnt); end
    end
    bus0.err_clr = 1'b1;
    tick();
    checks++; if (bus0.err_cnt !== 2'd0 || bus0.err_sticky !== 1'b0 || bus0.ch_parity_err !== 1'b1) begin
      errors++; $display("FAIL clr_prio got cnt=%0d sticky=%0b perr=%0b want 0/0/1", bus0.err_cnt, bus0.err_sticky, bus0.ch_parity_err); end
    bus0.ch_valid = 1'b0; bus0.err_clr = 1'b0;
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL sat_drop got v=%0b want 0", bus0.out_valid); end
    $display("saturate: counter held at 3, cleared");
  endtask

  task automatic test_enable();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 32'h20 + 32'(i);
      bus0.ch_valid = 1'b1; bus0.ch_data = d; bus0.ch_data_p = ^d;
      tick();
    end
    bus0.ch_en = 1'b0; bus0.ch_data = 32'h99; bus0.ch_data_p = ^bus0.ch_data;
    #1;
    checks++; if (bus0.ch_wait !== 1'b1) begin errors++; $display("FAIL en_wait got %0b want 1", bus0.ch_wait); end
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 32'h20 + 32'(i);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== d) begin
        errors++; $display("FAIL en_drain[%0d] got v=%0b d=%h want v=1 d=%h", i, bus0.out_valid, bus0.out_data, d); end
      tick();
    end
    checks++; if (bus0.out_valid !== 1'b0 || bus0.fifo_margin !== 5'd16) begin
      errors++; $display("FAIL en_end got v=%0b margin=%0d want 0/16", bus0.out_valid, bus0.fifo_margin); end
    bus0.out_ready = 1'b0; bus0.ch_valid = 1'b0; bus0.ch_en = 1'b1;
    $display("enable: 5 drained while disabled");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 32'h40 + 32'(i);
      bus0.ch_valid = 1'b1; bus0.ch_data = d; bus0.ch_data_p = ^d;
      tick();
    end
    checks++; if (bus0.fifo_margin !== 5'd8) begin errors++; $display("FAIL mid_margin got %0d want 8", bus0.fifo_margin); end
    rst = 1'b1;
    tick();
    checks++; if (bus0.out_valid !== 1'b0 || bus0.fifo_margin !== 5'd16 || bus0.ch_wait !== 1'b1) begin
      errors++; $display("FAIL mid_rst got v=%0b margin=%0d wait=%0b want 0/16/1", bus0.out_valid, bus0.fifo_margin, bus0.ch_wait); end
    rst = 1'b0; bus0.ch_valid = 1'b0;
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_noacc got v=%0b want 0", bus0.out_valid); end
    $display("reset_mid: buffer discarded");
  endtask

  task automatic test_odd();
    bus1.ch_en = 1'b1; bus1.ch_valid = 1'b1; bus1.ch_data = 32'h1; bus1.ch_data_p = 1'b0;
    tick();
    checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 32'h1 || bus1.ch_parity_err !== 1'b0) begin
      errors++; $display("FAIL odd_good got v=%0b d=%h perr=%0b want 1/1/0", bus1.out_valid, bus1.out_data, bus1.ch_parity_err); end
    bus1.ch_data_p = 1'b1;
    tick();
    bus1.ch_valid = 1'b0;
    checks++; if (bus1.ch_parity_err !== 1'b1 || bus1.err_cnt !== 8'd1 || bus1.fifo_margin !== 5'd15) begin
      errors++; $display("FAIL odd_bad got perr=%0b cnt=%0d margin=%0d want 1/1/15", bus1.ch_parity_err, bus1.err_cnt, bus1.fifo_margin); end
    $display("odd: p=0 accepted, p=1 dropped");
  endtask

  initial begin
    bus0.ch_en = 1'b0; bus0.ch_data = '0; bus0.ch_data_p = 1'b0; bus0.ch_valid = 1'b0;
    bus0.err_clr = 1'b0; bus0.out_ready = 1'b0;
    bus1.ch_en = 1'b0; bus1.ch_data = '0; bus1.ch_data_p = 1'b0; bus1.ch_valid = 1'b0;
    bus1.err_clr = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_parity_err();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_odd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
